// File: rtl/mem_arbiter_pkg.sv
// Shared codes for the IF/MEM byte-wide memory arbiter: size codes, arbiter
// states, owner codes and small decode helpers.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_own_e;

  // Size code 11 is treated as a word.
  function automatic logic [2:0] size_beats(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte beat sequencer: loaded with a base address and beat count, it steps the
// byte address (wrapping mod 2^ADDR_W) and flags the last and one-past-last beat.
module mem_arbiter_byte_seq #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [2:0]        i_n,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_beat,
  output logic              o_last,
  output logic              o_end
);

  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_beat;
  logic [2:0]        r_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_beat <= 3'd0;
      r_n    <= 3'd0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_beat <= 3'd0;
      r_n    <= i_n;
    end else if (i_adv) begin
      r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      r_beat <= r_beat + 3'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_beat = r_beat;
  assign o_last = (r_beat == r_n - 3'd1);
  assign o_end  = (r_beat == r_n);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise MEM always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_done,
  output logic [31:0]       o_if_inst,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [1:0]        i_mem_size,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  output logic              o_mem_done,
  output logic [31:0]       o_mem_rdata,
  output logic              o_stallreq_if,
  output logic              o_stallreq_mem,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_dout,
  input  logic [7:0]        i_ram_din
);

  arb_state_e r_state, w_state_next;
  arb_own_e   r_own, w_own_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [31:0] r_buf, w_buf_next;
  logic [31:0] r_if_inst, w_if_inst_next;
  logic [31:0] r_mem_rdata, w_mem_rdata_next;
  logic        r_if_done, w_if_done_next;
  logic        r_mem_done, w_mem_done_next;
  logic        r_ram_we, w_ram_we_next;
  logic [7:0]  r_ram_dout, w_ram_dout_next;

  logic              w_seq_load, w_seq_adv;
  logic [ADDR_W-1:0] w_seq_base, w_seq_addr;
  logic [2:0]        w_seq_n, w_beat;
  logic              w_seq_last, w_seq_end;
  logic [1:0]        w_lane;
  logic              w_turn, w_if_ok, w_pick_mem, w_pick_if;

  mem_arbiter_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_byte_seq (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_seq_load),
    .i_base (w_seq_base),
    .i_n    (w_seq_n),
    .i_adv  (w_seq_adv),
    .o_addr (w_seq_addr),
    .o_beat (w_beat),
    .o_last (w_seq_last),
    .o_end  (w_seq_end)
  );

  assign w_turn  = r_if_done | r_mem_done;
  assign w_if_ok = i_if_req & ~i_if_flush;
  // Read data for beat k lands while beat k+1 is addressed.
  assign w_lane  = w_beat[1:0] - 2'd1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_rr_if;
  logic w_contest;
  assign w_contest  = i_mem_req & w_if_ok;
  assign w_pick_mem = i_mem_req & ~(w_contest & r_rr_if);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_if <= 1'b0;
    end else if (r_state == ARB_IDLE && !w_turn && w_contest) begin
      r_rr_if <= w_pick_mem;
    end
  end
`else
  assign w_pick_mem = i_mem_req;
`endif
  assign w_pick_if = w_if_ok & ~w_pick_mem;

  always_comb begin
    w_state_next     = r_state;
    w_own_next       = r_own;
    w_wdata_next     = r_wdata;
    w_buf_next       = r_buf;
    w_if_inst_next   = r_if_inst;
    w_mem_rdata_next = r_mem_rdata;
    w_if_done_next   = 1'b0;
    w_mem_done_next  = 1'b0;
    w_ram_we_next    = 1'b0;
    w_ram_dout_next  = r_ram_dout;
    w_seq_load       = 1'b0;
    w_seq_adv        = 1'b0;
    w_seq_base       = i_if_addr;
    w_seq_n          = 3'd4;
    unique case (r_state)
      ARB_IDLE: begin
        if (!w_turn) begin
          if (w_pick_mem) begin
            w_seq_load   = 1'b1;
            w_seq_base   = i_mem_addr;
            w_seq_n      = size_beats(i_mem_size);
            w_own_next   = OWN_MEM;
            w_wdata_next = i_mem_wdata;
            w_buf_next   = '0;
            if (i_mem_we) begin
              w_state_next    = ARB_WR;
              w_ram_we_next   = 1'b1;
              w_ram_dout_next = i_mem_wdata[7:0];
            end else begin
              w_state_next = ARB_RD;
            end
          end else if (w_pick_if) begin
            w_seq_load   = 1'b1;
            w_own_next   = OWN_IF;
            w_buf_next   = '0;
            w_state_next = ARB_RD;
          end
        end
      end
      ARB_RD: begin
        if (r_own == OWN_IF && i_if_flush) begin
          w_state_next = ARB_IDLE;
        end else begin
          w_seq_adv = 1'b1;
          if (w_beat != 3'd0) begin
            w_buf_next[{w_lane, 3'b000} +: 8] = i_ram_din;
          end
          if (w_seq_end) begin
            w_state_next = ARB_IDLE;
            if (r_own == OWN_IF) begin
              w_if_done_next = 1'b1;
              w_if_inst_next = w_buf_next;
            end else begin
              w_mem_done_next  = 1'b1;
              w_mem_rdata_next = w_buf_next;
            end
          end
        end
      end
      ARB_WR: begin
        w_seq_adv = 1'b1;
        if (w_seq_last) begin
          w_state_next    = ARB_IDLE;
          w_mem_done_next = 1'b1;
        end else begin
          w_ram_we_next   = 1'b1;
          w_ram_dout_next = lane_byte(r_wdata, w_beat[1:0] + 2'd1);
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_own       <= OWN_IF;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_dout  <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_own       <= w_own_next;
      r_wdata     <= w_wdata_next;
      r_buf       <= w_buf_next;
      r_if_inst   <= w_if_inst_next;
      r_mem_rdata <= w_mem_rdata_next;
      r_if_done   <= w_if_done_next;
      r_mem_done  <= w_mem_done_next;
      r_ram_we    <= w_ram_we_next;
      r_ram_dout  <= w_ram_dout_next;
    end
  end

  assign o_if_done      = r_if_done;
  assign o_if_inst      = r_if_inst;
  assign o_mem_done     = r_mem_done;
  assign o_mem_rdata    = r_mem_rdata;
  assign o_stallreq_if  = i_if_req & ~r_if_done;
  assign o_stallreq_mem = i_mem_req & ~r_mem_done;
  assign o_ram_addr     = w_seq_addr;
  assign o_ram_we       = r_ram_we;
  assign o_ram_dout     = r_ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stallreq_if, stallreq_mem;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [0:65535];
  logic [31:0] tr_addr [0:7];
  logic        tr_we   [0:7];
  logic [7:0]  tr_dout [0:7];
  logic        tr_stall[0:7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .i_if_flush     (if_flush),
    .o_if_done      (if_done),
    .o_if_inst      (if_inst),
    .i_mem_req      (mem_req),
    .i_mem_we       (mem_we),
    .i_mem_size     (mem_size),
    .i_mem_addr     (mem_addr),
    .i_mem_wdata    (mem_wdata),
    .o_mem_done     (mem_done),
    .o_mem_rdata    (mem_rdata),
    .o_stallreq_if  (stallreq_if),
    .o_stallreq_mem (stallreq_mem),
    .o_ram_addr     (ram_addr),
    .o_ram_we       (ram_we),
    .o_ram_dout     (ram_dout),
    .i_ram_din      (ram_din)
  );

  // 64 KiB aliased byte RAM; read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[15:0]] <= ram_dout;
    ram_din <= ram[ram_addr[15:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_if(input logic [31:0] addr, output int c);
    c = 0;
    if_req  = 1'b1;
    if_addr = addr;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        tr_addr[k-1]  = ram_addr;
        tr_stall[k-1] = stallreq_if;
      end
      if (if_done) begin
        c = k;
        break;
      end
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int c);
    c = 0;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_size  = size;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        tr_addr[k-1]  = ram_addr;
        tr_we[k-1]    = ram_we;
        tr_dout[k-1]  = ram_dout;
        tr_stall[k-1] = stallreq_mem;
      end
      if (mem_done) begin
        c = k;
        break;
      end
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic contest(input string tag, input int exp_if, input int exp_mem);
    int ci = 0;
    int cm = 0;
    if_req   = 1'b1;
    if_addr  = 32'h100;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_size = SIZE_B;
    mem_addr = 32'h2001;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_done) begin
        cm = k;
        mem_req = 1'b0;
      end
      if (if_done) begin
        ci = k;
        if_req = 1'b0;
      end
      if (ci != 0 && cm != 0) break;
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    check_eq({tag, "_if_cyc"}, ci, exp_if);
    check_eq({tag, "_mem_cyc"}, cm, exp_mem);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wv;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0400] = 8'h93; ram[16'h0401] = 8'h00; ram[16'h0402] = 8'h10; ram[16'h0403] = 8'h00;
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;

    rst = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = SIZE_B; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_ram_dout", ram_dout, 8'h00);
    check_eq("rst_dones", {if_done, mem_done}, 2'b00);
    check_eq("rst_if_inst", if_inst, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word fetch
    run_if(32'h100, cyc);
    check_eq("fetch_cyc", cyc, 6);
    check_eq("fetch_inst", if_inst, 32'h0000_0513);
    for (int i = 0; i < 4; i++) check_eq("fetch_addr", tr_addr[i], 32'h100 + i);
    check_eq("fetch_stall_busy", tr_stall[0], 1'b1);
    check_eq("fetch_stall_done", tr_stall[5], 1'b0);

    // Word store
    wv = 32'hDEAD_BEEF;
    run_mem(1'b1, SIZE_W, 32'h2000, wv, cyc);
    check_eq("store_cyc", cyc, 5);
    for (int i = 0; i < 4; i++) begin
      check_eq("store_we", tr_we[i], 1'b1);
      check_eq("store_addr", tr_addr[i], 32'h2000 + i);
      check_eq("store_byte", tr_dout[i], wv[8*i +: 8]);
    end
    check_eq("store_we_done", tr_we[4], 1'b0);
    check_eq("store_ram", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, wv);

    // Byte and half loads
    run_mem(1'b0, SIZE_B, 32'h2001, 32'h0, cyc);
    check_eq("ldb_cyc", cyc, 3);
    check_eq("ldb_data", mem_rdata, 32'h0000_00BE);
    run_mem(1'b0, SIZE_H, 32'h2002, 32'h0, cyc);
    check_eq("ldh_cyc", cyc, 4);
    check_eq("ldh_data", mem_rdata, 32'h0000_DEAD);

    // Size code 11 reads a full word
    run_mem(1'b0, 2'b11, 32'h100, 32'h0, cyc);
    check_eq("ld11_cyc", cyc, 6);
    check_eq("ld11_data", mem_rdata, 32'h0000_0513);

    // Address wrap at the top of the space
    run_mem(1'b0, SIZE_W, 32'hFFFF_FFFE, 32'h0, cyc);
    check_eq("wrap_cyc", cyc, 6);
    check_eq("wrap_data", mem_rdata, 32'h4433_2211);
    for (int i = 0; i < 4; i++) begin
      a = 32'hFFFF_FFFE + i;
      check_eq("wrap_addr", tr_addr[i], a);
    end
    check_eq("inst_hold", if_inst, 32'h0000_0513);

    // Flush at beat 2, then fetch the branch target
    if_req  = 1'b1;
    if_addr = 32'h300;
    repeat (3) @(negedge clk);
    check_eq("flush_beat2_addr", ram_addr, 32'h302);
    if_flush = 1'b1;
    if_addr  = 32'h400;
    @(negedge clk);
    if_flush = 1'b0;
    check_eq("flush_no_done", if_done, 1'b0);
    check_eq("flush_no_we", ram_we, 1'b0);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("flush_target_addr", ram_addr, 32'h400);
      if (if_done) begin
        cyc = k;
        break;
      end
    end
    if_req = 1'b0;
    check_eq("flush_refetch_cyc", cyc, 6);
    check_eq("flush_refetch_inst", if_inst, 32'h0010_0093);
    @(negedge clk);

    // Simultaneous requests
    contest("contest1", 10, 3);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    contest("contest2", 6, 10);
`else
    contest("contest2", 10, 3);
`endif

    // Reset in the middle of a store
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_size  = SIZE_W;
    mem_addr  = 32'h3000;
    mem_wdata = 32'h1122_3344;
    repeat (2) @(negedge clk);
    check_eq("midstore_we", ram_we, 1'b1);
    rst     = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    check_eq("rst2_ram_we", ram_we, 1'b0);
    check_eq("rst2_ram_addr", ram_addr, 32'h0);
    check_eq("rst2_ram_dout", ram_dout, 8'h00);
    check_eq("rst2_dones", {if_done, mem_done}, 2'b00);
    check_eq("rst2_if_inst", if_inst, 32'h0);
    check_eq("rst2_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
